// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00 on {a,b}.
package qdec_pkg;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   localparam int INIT_CYCLES = 3;

   // Forward successor of each {a,b} code.
   localparam logic [1:0] FWD_NEXT [4] = '{
      2'b01,
      2'b11,
      2'b00,
      2'b10
   };

endpackage

// File: rtl/qdec_debounce.sv
// Two-flop synchroniser plus stability filter for one encoder pin.
// load bypasses the filter so the level can track the pin at start-up.
module qdec_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   input  logic load,
   output logic sync,
   output logic level
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync  <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= pin;
         sync  <= sync1;
         if (load) begin
            level <= sync;
            cnt   <= '0;
         end else if (sync == level) begin
            cnt   <= '0;
         end else if (cnt == CW'(DEB_CYCLES)) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder to step/dir decoder with illegal-edge detection.
// Define QDEC_POSITION_EN to add the pos_clr input and position register.
module quadrature_step_decoder
   import qdec_pkg::*;
#(
   parameter int DEB_CYCLES = 16,
   parameter bit X4_MODE    = 1'b1
`ifdef QDEC_POSITION_EN
   ,
   parameter int POS_W      = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
`ifdef QDEC_POSITION_EN
   input  logic             pos_clr,
   output logic [POS_W-1:0] position,
`endif
   input  logic             a_in,
   input  logic             b_in,
   input  logic             err_clr,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic             err_sticky
);

   state_t     state, state_nxt;
   logic [1:0] init_cnt, init_nxt;
   logic [1:0] prev, prev_nxt, cur;
   logic       sa, sb, fa, fb, load;
   logic       step_nxt, dir_nxt, err_nxt;
   logic       fwd, rev, dbl, x1_edge;

   assign load = (state == S_INIT);

   qdec_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk   (clk),
      .rst   (rst),
      .pin   (a_in),
      .load  (load),
      .sync  (sa),
      .level (fa)
   );

   qdec_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk   (clk),
      .rst   (rst),
      .pin   (b_in),
      .load  (load),
      .sync  (sb),
      .level (fb)
   );

   assign cur     = {fa, fb};
   assign fwd     = (cur == FWD_NEXT[prev]);
   assign rev     = (prev == FWD_NEXT[cur]);
   assign dbl     = &(cur ^ prev);
   assign x1_edge = (prev == 2'b01 && cur == 2'b11)
                 || (prev == 2'b11 && cur == 2'b01);

   always_comb begin
      state_nxt = state;
      init_nxt  = init_cnt;
      prev_nxt  = prev;
      step_nxt  = 1'b0;
      err_nxt   = 1'b0;
      dir_nxt   = dir;
      unique case (state)
         S_INIT: begin
            prev_nxt = {sa, sb};
            if (init_cnt == 2'(INIT_CYCLES - 1)) begin
               state_nxt = S_RUN;
               init_nxt  = 2'd0;
            end else begin
               init_nxt  = init_cnt + 2'd1;
            end
         end
         S_RUN: begin
            prev_nxt = cur;
            unique case (1'b1)
               dbl: err_nxt = 1'b1;
               fwd, rev: begin
                  if (X4_MODE || x1_edge) begin
                     step_nxt = 1'b1;
                     dir_nxt  = fwd;
                  end
               end
               default: ;
            endcase
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // A pending or visible err keeps the sticky flag set over err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT;
         init_cnt   <= 2'd0;
         prev       <= 2'b00;
         step       <= 1'b0;
         dir        <= 1'b1;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_nxt;
         init_cnt   <= init_nxt;
         prev       <= prev_nxt;
         step       <= step_nxt;
         dir        <= dir_nxt;
         err        <= err_nxt;
         err_sticky <= err_nxt | err
                     | (err_sticky & ~err_clr);
      end
   end

`ifdef QDEC_POSITION_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         position <= '0;
      end else if (pos_clr) begin
         position <= '0;
      end else if (step) begin
         if (dir)
            position <= position + 1'b1;
         else
            position <= position - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Bench for quadrature_step_decoder: X4 and X1 instances on shared pins,
// checked every cycle against a Gray-index model plus literal expectations.
module tb_quadrature_step_decoder;

   localparam int DEB = 4;
   localparam int PW  = 4;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic a_in    = 1'b0;
   logic b_in    = 1'b0;
   logic err_clr = 1'b0;
   logic pos_clr = 1'b0;

   logic step_q [2];
   logic dir_q  [2];
   logic err_q  [2];
   logic st_q   [2];
`ifdef QDEC_POSITION_EN
   logic [PW-1:0] pos_q [2];
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int up  [2];
   int dn  [2];
   int ner [2];
   int first_step = -1;
   int t0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   quadrature_step_decoder #(
      .DEB_CYCLES (DEB),
      .X4_MODE    (1'b1)
`ifdef QDEC_POSITION_EN
      ,
      .POS_W      (PW)
`endif
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
`ifdef QDEC_POSITION_EN
      .pos_clr    (pos_clr),
      .position   (pos_q[0]),
`endif
      .a_in       (a_in),
      .b_in       (b_in),
      .err_clr    (err_clr),
      .step       (step_q[0]),
      .dir        (dir_q[0]),
      .err        (err_q[0]),
      .err_sticky (st_q[0])
   );

   quadrature_step_decoder #(
      .DEB_CYCLES (DEB),
      .X4_MODE    (1'b0)
`ifdef QDEC_POSITION_EN
      ,
      .POS_W      (PW)
`endif
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
`ifdef QDEC_POSITION_EN
      .pos_clr    (pos_clr),
      .position   (pos_q[1]),
`endif
      .a_in       (a_in),
      .b_in       (b_in),
      .err_clr    (err_clr),
      .step       (step_q[1]),
      .dir        (dir_q[1]),
      .err        (err_q[1]),
      .err_sticky (st_q[1])
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // Model: index in the forward sequence 00,01,11,10.
   function automatic int gidx(input logic [1:0] c);
      case (c)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   logic          ms1 [2];
   logic          ms2 [2];
   logic          mf  [2];
   logic          mh  [2][16];
   int            hn  [2];
   int            mcyc;
   logic [1:0]    mprev;
   logic          e_step [2];
   logic          e_dir  [2];
   logic          e_err  [2];
   logic          e_st   [2];
   logic [PW-1:0] e_pos  [2];

   always @(posedge clk or posedge rst) begin
      logic os2 [2];
      logic of  [2];
      logic ostep [2];
      logic odir  [2];
      logic oerr  [2];
      logic ok;
      int   d, pi, ci;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            ms1[i] = 1'b0; ms2[i] = 1'b0; mf[i] = 1'b0;
            hn[i] = 0;
            e_step[i] = 1'b0; e_dir[i] = 1'b1;
            e_err[i] = 1'b0; e_st[i] = 1'b0;
            e_pos[i] = '0;
         end
         mcyc  = 0;
         mprev = 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            os2[i] = ms2[i]; of[i] = mf[i];
            ostep[i] = e_step[i]; odir[i] = e_dir[i];
            oerr[i] = e_err[i];
         end
         if (mcyc < 3) begin
            for (int i = 0; i < 2; i++) begin
               mf[i] = os2[i];
               hn[i] = 0;
               e_step[i] = 1'b0;
               e_err[i]  = 1'b0;
            end
            mprev = {os2[0], os2[1]};
         end else begin
            pi = gidx(mprev);
            ci = gidx({of[0], of[1]});
            d  = (ci - pi + 4) % 4;
            for (int m = 0; m < 2; m++) begin
               e_err[m]  = (d == 2);
               e_step[m] = (d == 1 || d == 3) &&
                  (m == 0 || (pi + ci == 3 && pi != 0 && ci != 0));
               if (e_step[m]) e_dir[m] = (d == 1);
            end
            mprev = {of[0], of[1]};
            // Level moves after DEB+1 samples in a row that disagree.
            for (int i = 0; i < 2; i++) begin
               for (int k = 15; k > 0; k--) mh[i][k] = mh[i][k-1];
               mh[i][0] = os2[i];
               if (hn[i] < 16) hn[i]++;
               if (hn[i] >= DEB + 1) begin
                  ok = 1'b1;
                  for (int k = 0; k <= DEB; k++)
                     if (mh[i][k] == of[i]) ok = 1'b0;
                  if (ok) begin
                     mf[i] = ~of[i];
                     hn[i] = 0;
                  end
               end
            end
         end
         for (int m = 0; m < 2; m++) begin
            e_st[m] = (e_st[m] & ~err_clr) | e_err[m] | oerr[m];
            if (pos_clr)
               e_pos[m] = '0;
            else if (ostep[m])
               e_pos[m] = odir[m] ? e_pos[m] + 1'b1
                                  : e_pos[m] - 1'b1;
         end
         mcyc++;
         ms2[0] = ms1[0]; ms2[1] = ms1[1];
         ms1[0] = a_in;   ms1[1] = b_in;
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("dut%0d.step", m), 32'(step_q[m]), 32'(e_step[m]));
         chk($sformatf("dut%0d.dir", m), 32'(dir_q[m]), 32'(e_dir[m]));
         chk($sformatf("dut%0d.err", m), 32'(err_q[m]), 32'(e_err[m]));
         chk($sformatf("dut%0d.sticky", m), 32'(st_q[m]), 32'(e_st[m]));
`ifdef QDEC_POSITION_EN
         chk($sformatf("dut%0d.pos", m), 32'(pos_q[m]), 32'(e_pos[m]));
`endif
         if (step_q[m]) begin
            if (dir_q[m]) up[m]++;
            else          dn[m]++;
            if (m == 0 && first_step < 0) first_step = cyc;
         end
         if (err_q[m]) ner[m]++;
      end
   end

   task automatic hold(input logic a, input logic b, input int n);
      a_in = a;
      b_in = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      for (int m = 0; m < 2; m++) begin
         up[m] = 0; dn[m] = 0; ner[m] = 0;
      end
      first_step = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [1:0] wrap_seq [8];
   bit seen;

   initial begin
      wrap_seq = '{2'b11, 2'b10, 2'b00, 2'b01,
                   2'b11, 2'b10, 2'b00, 2'b01};
      clr_cnt();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.step", 32'(step_q[0]), 0);
      chk("rst.dir", 32'(dir_q[0]), 1);
      chk("rst.sticky", 32'(st_q[0]), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      hold(1'b0, 1'b0, 12);

      // forward cycle
      clr_cnt();
      t0 = cyc;
      hold(1'b0, 1'b1, 10);
      hold(1'b1, 1'b1, 10);
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);
      chk("t1.up", up[0], 4);
      chk("t1.dn", dn[0], 0);
      chk("t1.latency", first_step - (t0 + 1), 7);
      chk("t1.x1_up", up[1], 1);
      chk("t1.x1_dn", dn[1], 0);
`ifdef QDEC_POSITION_EN
      chk("t1.pos", 32'(pos_q[0]), 4);
`endif

      // reverse cycle
      clr_cnt();
      hold(1'b1, 1'b0, 10);
      hold(1'b1, 1'b1, 10);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 10);
      chk("t2.dn", dn[0], 4);
      chk("t2.up", up[0], 0);
      chk("t2.x1_dn", dn[1], 1);
      chk("t2.dir", 32'(dir_q[0]), 0);
`ifdef QDEC_POSITION_EN
      chk("t2.pos", 32'(pos_q[0]), 0);
`endif

      // glitch shorter than the filter, then a held level
      clr_cnt();
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 20);
      chk("t3.glitch_steps", up[0] + dn[0], 0);
      chk("t3.glitch_err", ner[0], 0);
      hold(1'b1, 1'b0, 12);
      chk("t3.held_dn", dn[0], 1);
      chk("t3.held_dir", 32'(dir_q[0]), 0);
      chk("t3.x1_silent", up[1] + dn[1], 0);
      hold(1'b0, 1'b0, 12);
      chk("t3.back_up", up[0], 1);

      // double edge
      clr_cnt();
      hold(1'b1, 1'b1, 12);
      chk("t4.err", ner[0], 1);
      chk("t4.no_step", up[0] + dn[0], 0);
      chk("t4.sticky", 32'(st_q[0]), 1);
      chk("t4.x1_err", ner[1], 1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4.cleared", 32'(st_q[0]), 0);
      a_in = 1'b0;
      b_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (err_q[0]) seen = 1'b1;
      end
      chk("t4.err2_seen", 32'(seen), 1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4.set_wins", 32'(st_q[0]), 1);
      hold(1'b0, 1'b0, 6);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("t4.cleared2", 32'(st_q[0]), 0);
      @(posedge clk); #1;

      // jitter A with B high
      clr_cnt();
      hold(1'b0, 1'b1, 10);
      hold(1'b1, 1'b1, 10);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 10);
      chk("t5.x1_up", up[1], 1);
      chk("t5.x1_dn", dn[1], 1);
      chk("t5.x4_up", up[0], 2);
      chk("t5.x4_dn", dn[0], 2);

      // clear over a step, then wrap
      pos_clr = 1'b1;
      hold(1'b0, 1'b1, 10);
      pos_clr = 1'b0;
`ifdef QDEC_POSITION_EN
      chk("t6.pos_clr", 32'(pos_q[0]), 0);
`endif
      for (int i = 0; i < 8; i++)
         hold(wrap_seq[i][1], wrap_seq[i][0], 10);
`ifdef QDEC_POSITION_EN
      chk("t6.wrap", 32'(pos_q[0]), 32'h8);
`endif

      // reset mid-rotation with both pins high
      hold(1'b1, 1'b1, 10);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t6.rst_step", 32'(step_q[0]), 0);
      chk("t6.rst_dir", 32'(dir_q[0]), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      clr_cnt();
      hold(1'b1, 1'b1, 20);
      chk("t6.no_step", up[0] + dn[0], 0);
      chk("t6.no_err", ner[0], 0);
      chk("t6.dir", 32'(dir_q[0]), 1);
`ifdef QDEC_POSITION_EN
      chk("t6.pos", 32'(pos_q[0]), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
